// File: rtl/cmos_rtc_regs.sv
// PCF8583-style clock/RAM register file with free-running BCD calendar.
// Reads are registered; the MiSTer RTC bus reloads the clock on each rtc[64] toggle.
module cmos_rtc_regs #(
  parameter int ADDR_W = 8,
  parameter int CLK_HZ = 24000000,
  parameter logic [ADDR_W-1:0] YEAR_REG = 8'hC0,
  parameter int CENTURY = 20,
  parameter MIF = "cmos.mif"
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [64:0]       rtc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_valid
);

  localparam int DIV = CLK_HZ / 100;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [ADDR_W-1:0] CENT_REG = YEAR_REG + 1'b1;

  logic [7:0] ram [2**ADDR_W];

  logic [7:0]    ctrl, hsec, sec, min, hour;
  logic [5:0]    date;
  logic [4:0]    month;
  logic [2:0]    wday;
  logic [6:0]    year;
  logic [PW-1:0] pre;
  logic [2:0]    sync;

  logic is_low, is_year, is_cent, is_ram;
  logic wr_time, pre_clr, ld, tick;
  logic unused_rtc;

  assign is_low  = addr[ADDR_W-1:4] == '0;
  assign is_year = addr == YEAR_REG;
  assign is_cent = addr == CENT_REG;
  assign is_ram  = !(is_low || is_year || is_cent);

  assign wr_time = wr_en && (is_year ||
                   (is_low && addr[3:0] >= 4'h1 && addr[3:0] <= 4'h6));
  assign ld      = sync[1] ^ sync[2];
  assign pre_clr = ld || (wr_en && is_low &&
                   (addr[3:0] == 4'h1 || addr[3:0] == 4'h2));
  assign tick    = !ctrl[7] && pre == PRE_MAX;

  assign unused_rtc = ^{rtc[63:51], rtc[39:37], rtc[31:30]};

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
  endfunction

  logic [7:0] n_hsec, n_sec, n_min, n_hour;
  logic [5:0] n_date, dim;
  logic [4:0] n_month;
  logic [2:0] n_wday;
  logic [6:0] n_year;
  logic c_sec, c_min, c_hour, c_day, c_mon, c_year;

  always_comb begin
    dim = 6'h31;
    unique case (month)
      5'h02: dim = (year[1:0] == 2'b00) ? 6'h29 : 6'h28;
      5'h04, 5'h06, 5'h09, 5'h11: dim = 6'h30;
      default: dim = 6'h31;
    endcase
  end

  // One ripple of equality compares; every field settles in the same cycle
  always_comb begin
    n_sec   = sec;
    n_min   = min;
    n_hour  = hour;
    n_date  = date;
    n_wday  = wday;
    n_month = month;
    n_year  = year;
    c_sec   = hsec == 8'h99;
    n_hsec  = c_sec ? 8'h00 : bcd_inc(hsec);
    c_min   = c_sec && sec == 8'h59;
    c_hour  = c_min && min == 8'h59;
    c_day   = c_hour && hour == 8'h23;
    c_mon   = c_day && date == dim;
    c_year  = c_mon && month == 5'h12;
    if (c_sec)
      n_sec = (sec == 8'h59) ? 8'h00 : bcd_inc(sec);
    if (c_min)
      n_min = (min == 8'h59) ? 8'h00 : bcd_inc(min);
    if (c_hour)
      n_hour = (hour == 8'h23) ? 8'h00 : bcd_inc(hour);
    if (c_day) begin
      n_date = (date == dim) ? 6'h01 : 6'(bcd_inc({2'b00, date}));
      n_wday = (wday == 3'd6) ? 3'd0 : wday + 3'd1;
    end
    if (c_mon)
      n_month = (month == 5'h12) ? 5'h01 : 5'(bcd_inc({3'b000, month}));
    if (c_year)
      n_year = (year == 7'd99) ? 7'd0 : year + 7'd1;
  end

  logic [7:0] lo_val, rd_mux;

  always_comb begin
    lo_val = 8'h00;
    unique case (addr[3:0])
      4'h0: lo_val = ctrl;
      4'h1: lo_val = hsec;
      4'h2: lo_val = sec;
      4'h3: lo_val = min;
      4'h4: lo_val = hour;
      4'h5: lo_val = {year[1:0], date};
      4'h6: lo_val = {wday, month};
      default: lo_val = 8'h00;
    endcase
    rd_mux = 8'h00;
    unique case (1'b1)
      is_low:  rd_mux = (wr_en && addr[3:0] <= 4'h6) ? wr_data : lo_val;
      is_year: rd_mux = wr_en ? {1'b0, wr_data[6:0]} : {1'b0, year};
      is_cent: rd_mux = 8'(CENTURY);
      default: rd_mux = wr_en ? wr_data : ram[addr];
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && is_ram)
      ram[addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= 8'h00;
      hsec     <= 8'h00;
      sec      <= 8'h00;
      min      <= 8'h00;
      hour     <= 8'h00;
      date     <= 6'h01;
      month    <= 5'h01;
      wday     <= 3'd0;
      year     <= 7'd0;
      pre      <= '0;
      sync     <= 3'b000;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      sync     <= {sync[1:0], rtc[64]};
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= rd_mux;
      if (wr_en && is_low && addr[3:0] == 4'h0)
        ctrl <= wr_data;
      if (pre_clr)
        pre <= '0;
      else if (!ctrl[7])
        pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
      if (ld) begin
        hsec  <= 8'h00;
        sec   <= rtc[7:0];
        min   <= rtc[15:8];
        hour  <= rtc[23:16];
        date  <= rtc[29:24];
        month <= rtc[36:32];
        wday  <= rtc[50:48];
        year  <= 7'(rtc[47:44]) * 7'd10 + 7'(rtc[43:40]);
      end else if (wr_time) begin
        if (is_year) begin
          year <= wr_data[6:0];
        end else begin
          unique case (addr[3:0])
            4'h1: hsec <= wr_data;
            4'h2: sec  <= wr_data;
            4'h3: min  <= wr_data;
            4'h4: hour <= wr_data;
            4'h5: begin
              year[1:0] <= wr_data[7:6];
              date      <= wr_data[5:0];
            end
            4'h6: begin
              wday  <= wr_data[7:5];
              month <= wr_data[4:0];
            end
            default: ;
          endcase
        end
      end else if (tick) begin
        hsec  <= n_hsec;
        sec   <= n_sec;
        min   <= n_min;
        hour  <= n_hour;
        date  <= n_date;
        wday  <= n_wday;
        month <= n_month;
        year  <= n_year;
      end
    end
  end

endmodule
